key_debounce: RTL and testbench

//  Conditions the raw active-low push buttons (KEY_N) ahead of proj2's control logic.
//  Per channel: 2-flop synchronizer, counter-based debounce FSM, clean active-high level,

---
 rtl/key_debounce_if.sv | 33 +++
 rtl/key_debounce.sv | 125 ++++++++++++
 tb/tb_key_debounce.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/key_debounce_if.sv
// key_debounce_if
//   Groups the per-channel button signals of key_debounce into one bundle.
//   key_n          raw active-low button pins, asynchronous to the clock
//   repeat_en      per-channel auto-repeat enable, synchronous
//   pressed        debounced level, 1 = pressed
//   press_pulse    one-cycle strobe on accepted press and on each auto-repeat
//   release_pulse  one-cycle strobe on accepted release
//   master drives the pins/enables, slave is the debouncer.
interface key_debounce_if #(
  parameter int WIDTH = 2
);
  logic [WIDTH-1:0] key_n;
  logic [WIDTH-1:0] repeat_en;
  logic [WIDTH-1:0] pressed;
  logic [WIDTH-1:0] press_pulse;
  logic [WIDTH-1:0] release_pulse;

  modport master (
    output key_n,
    output repeat_en,
    input  pressed,
    input  press_pulse,
    input  release_pulse
  );

  modport slave (
    input  key_n,
    input  repeat_en,
    output pressed,
    output press_pulse,
    output release_pulse
  );
endinterface

// File: rtl/key_debounce.sv
// key_debounce
//   Conditions raw active-low push buttons. Each channel has a 2-flop
//   synchronizer, a counter-based debounce FSM, a clean active-high level,
//   single-cycle press/release strobes and optional auto-repeat of the press
//   strobe while the button is held. Channels are fully independent.
// Ports
//   clk   sole clock, rising edge
//   rst   asynchronous active-high reset
//   bus   key_debounce_if slave: key_n, repeat_en in; pressed,
//         press_pulse, release_pulse out (all outputs registered)
module key_debounce #(
  parameter int WIDTH         = 2,
  parameter int DEBOUNCE_CYC  = 200000,
  parameter int REPEAT_DELAY  = 5000000,
  parameter int REPEAT_PERIOD = 1000000,
  parameter int CNT_W         = 24
) (
  input logic         clk,
  input logic         rst,
  key_debounce_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    HELD,
    REL
  } state_t;

  localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] REP_LAST    = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] REP_RELOAD  = CNT_W'(REPEAT_DELAY - REPEAT_PERIOD);

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    logic             sync1;
    logic             sync2;
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] rcnt;
    logic             pressed_q;
    logic             press_q;
    logic             release_q;

    // Two-flop synchronizer; resets to 1 so a reset looks like "released".
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync1 <= 1'b1;
        sync2 <= 1'b1;
      end else begin
        sync1 <= bus.key_n[i];
        sync2 <= sync1;
      end
    end

    // Debounce FSM: a level change is accepted only after the synchronized
    // input has held the new value for DEBOUNCE_CYC consecutive cycles.
    // Strobes default low every cycle so they last exactly one cycle.
    // The repeat counter reloads to REPEAT_DELAY-REPEAT_PERIOD after each
    // repeat strobe so later strobes come every REPEAT_PERIOD cycles; it is
    // left untouched in REL so a release glitch does not restart the delay.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state     <= IDLE;
        cnt       <= '0;
        rcnt      <= '0;
        pressed_q <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        press_q   <= 1'b0;
        release_q <= 1'b0;
        case (state)
          IDLE: begin
            if (!sync2) begin
              state <= ARM;
              cnt   <= CNT_W'(1);
            end
          end
          ARM: begin
            if (sync2) begin
              state <= IDLE;
            end else if (cnt == DEB_LAST) begin
              state     <= HELD;
              pressed_q <= 1'b1;
              press_q   <= 1'b1;
              rcnt      <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          HELD: begin
            if (sync2) begin
              state <= REL;
              cnt   <= CNT_W'(1);
            end else if (!bus.repeat_en[i]) begin
              rcnt <= '0;
            end else if (rcnt == REP_LAST) begin
              press_q <= 1'b1;
              rcnt    <= REP_RELOAD;
            end else begin
              rcnt <= rcnt + 1'b1;
            end
          end
          REL: begin
            if (!sync2) begin
              state <= HELD;
            end else if (cnt == DEB_LAST) begin
              state     <= IDLE;
              pressed_q <= 1'b0;
              release_q <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end

    assign bus.pressed[i]       = pressed_q;
    assign bus.press_pulse[i]   = press_q;
    assign bus.release_pulse[i] = release_q;
  end

endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce
//   Directed bench for key_debounce with DEBOUNCE_CYC=4, REPEAT_DELAY=10,
//   REPEAT_PERIOD=3, WIDTH=2. Inputs change on the falling clock edge and
//   outputs are sampled on later falling edges. An input set at falling edge
//   0 is first sampled by the next rising edge; an accepted change then shows
//   up on the outputs at falling edge 6 (1 + DEBOUNCE_CYC rising edges later,
//   plus the synchronizer edge).
module tb_key_debounce;

  logic clk;
  logic rst;
  int   compared;
  int   mismatched;

  key_debounce_if #(.WIDTH(2)) bus ();

  key_debounce #(
    .WIDTH        (2),
    .DEBOUNCE_CYC (4),
    .REPEAT_DELAY (10),
    .REPEAT_PERIOD(3),
    .CNT_W        (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // 100 MHz-style free-running clock; absolute period is irrelevant here.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [1:0] keys, input logic [1:0] en);
    bus.key_n     = keys;
    bus.repeat_en = en;
  endtask

  task automatic checkOutput(input string tag, input logic [1:0] obs,
                             input logic [1:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag, input int i, input logic [1:0] ep,
                          input logic [1:0] epp, input logic [1:0] erp);
    checkOutput($sformatf("%s.pressed@%0d", tag, i), bus.pressed, ep);
    checkOutput($sformatf("%s.press@%0d", tag, i), bus.press_pulse, epp);
    checkOutput($sformatf("%s.release@%0d", tag, i), bus.release_pulse, erp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [1:0] ep;
    logic [1:0] epp;
    logic [1:0] erp;
    compared   = 0;
    mismatched = 0;

    // Reset with both keys held down: outputs stay 0 throughout reset.
    rst = 1'b1;
    applyStimulus(2'b00, 2'b00);
    cyc(3);
    checkAll("reset", 0, 2'b00, 2'b00, 2'b00);

    // Release reset; the held keys debounce as a fresh press.
    rst = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      cyc(1);
      ep  = (i >= 6) ? 2'b11 : 2'b00;
      epp = (i == 6) ? 2'b11 : 2'b00;
      checkAll("rstexit", i, ep, epp, 2'b00);
    end

    // Release both keys.
    applyStimulus(2'b11, 2'b00);
    for (int i = 1; i <= 8; i++) begin
      cyc(1);
      ep  = (i >= 6) ? 2'b00 : 2'b11;
      erp = (i == 6) ? 2'b11 : 2'b00;
      checkAll("rel", i, ep, 2'b00, erp);
    end

    // Bounce on channel 0: lows of 2 cycles never reach the debounce count.
    for (int i = 0; i < 30; i++) begin
      if (i < 20) applyStimulus({1'b1, ((i / 2) % 2 == 0) ? 1'b0 : 1'b1}, 2'b00);
      else        applyStimulus(2'b11, 2'b00);
      cyc(1);
      checkAll("bounce", i, 2'b00, 2'b00, 2'b00);
    end

    // Clean press then release on channel 0, repeat disabled.
    applyStimulus(2'b10, 2'b00);
    for (int i = 1; i <= 46; i++) begin
      cyc(1);
      ep  = (i >= 6 && i < 40) ? 2'b01 : 2'b00;
      epp = (i == 6) ? 2'b01 : 2'b00;
      erp = (i == 40) ? 2'b01 : 2'b00;
      checkAll("clean", i, ep, epp, erp);
      if (i == 34) applyStimulus(2'b11, 2'b00);
    end

    // Auto-repeat on channel 1: press at 6, repeats at 16,19,22,25;
    // enable dropped after 26 and raised again after 30, giving the full
    // delay again before the next repeat at 40; released after 40.
    applyStimulus(2'b01, 2'b10);
    for (int i = 1; i <= 48; i++) begin
      cyc(1);
      ep  = (i >= 6 && i < 46) ? 2'b10 : 2'b00;
      epp = (i == 6 || i == 16 || i == 19 || i == 22 || i == 25 || i == 40)
            ? 2'b10 : 2'b00;
      erp = (i == 46) ? 2'b10 : 2'b00;
      checkAll("repeat", i, ep, epp, erp);
      if (i == 26) applyStimulus(2'b01, 2'b00);
      if (i == 30) applyStimulus(2'b01, 2'b10);
      if (i == 40) applyStimulus(2'b11, 2'b10);
    end
    applyStimulus(2'b11, 2'b00);

    // Release glitch on channel 0 while channel 1 really releases.
    applyStimulus(2'b00, 2'b00);
    for (int i = 1; i <= 28; i++) begin
      cyc(1);
      ep[0]  = (i >= 6 && i < 26);
      ep[1]  = (i >= 6 && i < 16);
      epp    = (i == 6) ? 2'b11 : 2'b00;
      erp[0] = (i == 26);
      erp[1] = (i == 16);
      checkAll("glitch", i, ep, epp, erp);
      if (i == 10) applyStimulus(2'b11, 2'b00);
      if (i == 12) applyStimulus(2'b10, 2'b00);
      if (i == 20) applyStimulus(2'b11, 2'b00);
    end

    // Reset while HELD: outputs clear at once, then a fresh full debounce.
    applyStimulus(2'b00, 2'b00);
    cyc(8);
    checkOutput("heldpre.pressed", bus.pressed, 2'b11);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 checkAll("heldrst", 0, 2'b00, 2'b00, 2'b00);
    cyc(2);
    rst = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      cyc(1);
      ep  = (i >= 6) ? 2'b11 : 2'b00;
      epp = (i == 6) ? 2'b11 : 2'b00;
      checkAll("heldexit", i, ep, epp, 2'b00);
    end

    // Reset while ARM on channel 0: the partial debounce is abandoned.
    applyStimulus(2'b11, 2'b00);
    cyc(8);
    applyStimulus(2'b10, 2'b00);
    cyc(4);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 checkAll("armrst", 0, 2'b00, 2'b00, 2'b00);
    applyStimulus(2'b11, 2'b00);
    cyc(2);
    rst = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      cyc(1);
      checkAll("armexit", i, 2'b00, 2'b00, 2'b00);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
